// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared encodings and sizes for the transaction-layer VC scheduler
// Contents: FSM state encoding, channel count, counter width, threshold width.
package tl_pkg;

   localparam int NUM_VC = 4;
   localparam int IDX_W  = 2;
   localparam int CNT_W  = 5;
   localparam int THR_W  = 3;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } tl_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin arbiter
// Ports:
//   req     in  [3:0]  request vector (one bit per VC)
//   ptr     in  [1:0]  index of the last granted VC
//   gnt     out [3:0]  one-hot grant, zero when no request
//   gnt_idx out [1:0]  binary index of the grant
module rr_arbiter4
   import tl_pkg::*;
(
   input  logic [NUM_VC-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_VC-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // Search ptr+1, ptr+2, ptr+3 and finally ptr itself; the 2-bit add wraps mod 4.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 1; k <= NUM_VC; k++) begin
         cand = ptr + k[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            gnt[cand]   = 1'b1;
            gnt_idx     = cand;
         end
      end
   end

endmodule

// File: rtl/tl_vc_scheduler.sv
// rtl/tl_vc_scheduler.sv - PCIe transaction-layer VC scheduler with hysteresis flow control
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   init             hold in INIT and sample thresholds
//   umbral_alto/bajo output-FIFO stop / resume thresholds
//   vc_empty         empty flags of VC FIFOs 0..3
//   fifo_error       overflow/underflow flags (bits 0..3 VC FIFOs, bit 4 output FIFO)
//   out_count        output FIFO occupancy
//   req, idx         forwarded-word counter readback request
//   pop_vc           one-hot pop to VC FIFOs (combinational)
//   push_out,sel_out output FIFO push and data select, one cycle behind pop_vc
//   idle, state      FSM status
//   pause            hysteresis flag
//   contador, valid  counter readback value and strobe
module tl_vc_scheduler
   import tl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [THR_W-1:0]  umbral_alto,
   input  logic [THR_W-1:0]  umbral_bajo,
   input  logic [NUM_VC-1:0] vc_empty,
   input  logic [NUM_VC:0]   fifo_error,
   input  logic [3:0]        out_count,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   output logic [NUM_VC-1:0] pop_vc,
   output logic              push_out,
   output logic [IDX_W-1:0]  sel_out,
   output logic              idle,
   output logic [2:0]        state,
   output logic              pause,
   output logic [CNT_W-1:0]  contador,
   output logic              valid
);

   tl_state_e         state_q, state_d;
   logic [THR_W-1:0]  alto_q, bajo_q;
   logic              pause_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  cnt_q [NUM_VC];
   logic [NUM_VC-1:0] vc_req, gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              any_req, any_err, pop_ok, below_alto;

   assign vc_req     = ~vc_empty;
   assign any_req    = |vc_req;
   assign any_err    = |fifo_error;
   assign below_alto = out_count < {1'b0, alto_q};

   rr_arbiter4 u_arb (
      .req     (vc_req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // The comparison against umbral_alto is live (not just via pause) so the pop
   // stops in the very cycle the level reaches the threshold.
   assign pop_ok = (state_q == ST_ACTIVE) && !pause_q && below_alto && any_req;
   assign pop_vc = pop_ok ? gnt : '0;

   assign state = state_q;
   assign idle  = (state_q == ST_IDLE);
   assign pause = pause_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (any_err)      state_d = ST_ERROR;
            else if (init)    state_d = ST_INIT;
            else if (any_req) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_err)                     state_d = ST_ERROR;
            else if (init)                   state_d = ST_INIT;
            else if (&vc_empty && !pop_ok)   state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RESET;
         alto_q   <= '0;
         bajo_q   <= '0;
         pause_q  <= 1'b0;
         ptr_q    <= 2'd3;
         push_out <= 1'b0;
         sel_out  <= '0;
         contador <= '0;
         valid    <= 1'b0;
         for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         push_out <= pop_ok;
         sel_out  <= pop_ok ? gnt_idx : '0;

         if (pop_ok) ptr_q <= gnt_idx;

         if (state_q == ST_INIT) begin
            alto_q <= umbral_alto;
            bajo_q <= umbral_bajo;
            for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= '0;
         end else if (pop_ok) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
         end

         // Set is tested first so it wins when the thresholds overlap.
         // Outside IDLE/ACTIVE the thresholds may be stale, so pause is kept clear
         // there (and frozen in ERROR).
         if (state_q == ST_IDLE || state_q == ST_ACTIVE) begin
            if (!below_alto)                          pause_q <= 1'b1;
            else if (out_count <= {1'b0, bajo_q})     pause_q <= 1'b0;
         end else if (state_q != ST_ERROR) begin
            pause_q <= 1'b0;
         end

         // Reads the pre-increment register value when the same VC pops this cycle.
         if (state_q == ST_RESET) begin
            contador <= '0;
            valid    <= 1'b0;
         end else if (req) begin
            contador <= (state_q == ST_INIT) ? '0 : cnt_q[idx];
            valid    <= 1'b1;
         end else begin
            valid    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tl_vc_scheduler.sv
// tb/tb_tl_vc_scheduler.sv - directed self-checking bench for tl_vc_scheduler
module tb_tl_vc_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] umbral_alto, umbral_bajo;
   logic [3:0] vc_empty;
   logic [4:0] fifo_error;
   logic [3:0] out_count;
   logic       req;
   logic [1:0] idx;
   logic [3:0] pop_vc;
   logic       push_out;
   logic [1:0] sel_out;
   logic       idle;
   logic [2:0] state;
   logic       pause;
   logic [4:0] contador;
   logic       valid;

   int n_asserts = 0;
   int n_fail    = 0;

   tl_vc_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .init        (init),
      .umbral_alto (umbral_alto),
      .umbral_bajo (umbral_bajo),
      .vc_empty    (vc_empty),
      .fifo_error  (fifo_error),
      .out_count   (out_count),
      .req         (req),
      .idx         (idx),
      .pop_vc      (pop_vc),
      .push_out    (push_out),
      .sel_out     (sel_out),
      .idle        (idle),
      .state       (state),
      .pause       (pause),
      .contador    (contador),
      .valid       (valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   logic [3:0] exp_pop [5];

   initial begin
      exp_pop[0] = 4'b0001; exp_pop[1] = 4'b0010; exp_pop[2] = 4'b0100;
      exp_pop[3] = 4'b1000; exp_pop[4] = 4'b0001;

      reset = 1'b0; init = 1'b0; umbral_alto = 3'd6; umbral_bajo = 3'd2;
      vc_empty = 4'hF; fifo_error = '0; out_count = '0; req = 1'b0; idx = '0;
      tick(); tick();
      chk("rst_state", state, 0);
      chk("rst_pop", pop_vc, 0);
      chk("rst_push", push_out, 0);
      chk("rst_sel", sel_out, 0);
      chk("rst_idle", idle, 0);
      chk("rst_pause", pause, 0);
      chk("rst_cont", contador, 0);
      chk("rst_valid", valid, 0);

      // Release reset with init held for three cycles.
      reset = 1'b1; init = 1'b1;
      tick(); chk("init_s1", state, 1);
      tick(); chk("init_s2", state, 1);
      tick(); chk("init_s3", state, 1);
      init = 1'b0;
      tick();
      chk("idle_state", state, 2);
      chk("idle_flag", idle, 1);
      chk("idle_pause", pause, 0);
      chk("idle_push", push_out, 0);

      // Round robin across all four VCs starting at VC0.
      vc_empty = 4'h0;
      #1 chk("idle_nopop", pop_vc, 0);
      tick();
      chk("act_state", state, 3);
      for (int i = 0; i < 5; i++) begin
         chk("rr_pop", pop_vc, exp_pop[i]);
         if (i > 0) begin
            chk("rr_push", push_out, 1);
            chk("rr_sel", sel_out, i - 1);
         end
         tick();
      end
      chk("rr_push_last", push_out, 1);
      chk("rr_sel_last", sel_out, 0);

      // Hysteresis: stop at 6, stay paused at 3, release at 2.
      out_count = 4'd6;
      #1 chk("fc_stop_now", pop_vc, 0);
      tick();
      chk("fc_pause_set", pause, 1);
      chk("fc_no_push", push_out, 0);
      out_count = 4'd3;
      #1 chk("fc_hold_pop", pop_vc, 0);
      tick();
      chk("fc_pause_hold", pause, 1);
      out_count = 4'd2;
      #1 chk("fc_reg_pause", pop_vc, 0);
      tick();
      chk("fc_pause_clr", pause, 0);
      chk("fc_resume", pop_vc, 4'b0010);

      // VC2 alone: 32 more pops on top of one earlier pop -> 33 -> wraps to 1.
      vc_empty = 4'b1011;
      #1 chk("vc2_pop", pop_vc, 4'b0100);
      for (int i = 0; i < 32; i++) tick();
      chk("vc2_push", push_out, 1);
      chk("vc2_sel", sel_out, 2);
      vc_empty = 4'hF; req = 1'b1; idx = 2'd2;
      tick();
      chk("rd_wrap_val", contador, 1);
      chk("rd_wrap_valid", valid, 1);
      chk("to_idle", state, 2);
      req = 1'b0;
      tick();
      chk("rd_valid_drop", valid, 0);
      chk("rd_hold", contador, 1);
      req = 1'b1; idx = 2'd0;
      tick();
      chk("rd_vc0", contador, 2);
      req = 1'b0;

      // Single word on VC1, read its counter in the same cycle it pops.
      vc_empty = 4'b1101;
      tick();
      chk("vc1_active", state, 3);
      chk("vc1_pop", pop_vc, 4'b0010);
      req = 1'b1; idx = 2'd1;
      tick();
      chk("vc1_push", push_out, 1);
      chk("vc1_sel", sel_out, 1);
      chk("rd_preinc", contador, 1);
      vc_empty = 4'hF; req = 1'b0;
      tick();
      chk("vc1_idle_state", state, 2);
      chk("vc1_idle_flag", idle, 1);
      chk("vc1_no_push", push_out, 0);
      req = 1'b1;
      tick();
      chk("rd_postinc", contador, 2);
      req = 1'b0;

      // Output-FIFO error in ACTIVE.
      vc_empty = 4'h0;
      tick();
      chk("err_pre_active", state, 3);
      chk("err_pre_pop", pop_vc, 4'b0100);
      fifo_error = 5'b10000;
      tick();
      chk("err_state", state, 4);
      chk("err_pop_off", pop_vc, 0);
      chk("err_inflight", push_out, 1);
      chk("err_inflight_sel", sel_out, 2);
      tick();
      chk("err_push_done", push_out, 0);
      fifo_error = '0; init = 1'b1;
      tick();
      chk("err_sticky", state, 4);
      chk("err_sticky_pop", pop_vc, 0);
      reset = 1'b0;
      #1;
      chk("err_rst_state", state, 0);
      chk("err_rst_cont", contador, 0);
      reset = 1'b1; req = 1'b1; idx = 2'd2;
      tick();
      chk("reinit_state", state, 1);
      chk("rst_state_noread", valid, 0);
      tick();
      chk("init_read_valid", valid, 1);
      chk("init_read_zero", contador, 0);
      init = 1'b0; req = 1'b0;
      tick();
      chk("reidle", state, 2);

      // Asynchronous reset drops an in-flight push at once.
      tick();
      chk("re_active", state, 3);
      chk("re_pop", pop_vc, 4'b0001);
      tick();
      chk("re_push", push_out, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_drop_push", push_out, 0);
      chk("async_pop_off", pop_vc, 0);
      tick();
      reset = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
